// File: rtl/ttm4_fetch_unit_if.sv
// Fetch-unit bus: ROM fetch port, decoder-facing IR fields and decoder sequencing controls.
// The fetch unit is the master; the ROM/decoder/run-control side is the slave.
interface ttm4_fetch_unit_if #(
    parameter int unsigned PC_W      = 8,
    parameter int unsigned STK_DEPTH = 4
);
    localparam int unsigned SP_W = $clog2(STK_DEPTH) + 1;

    logic            RUN;
    logic [PC_W-1:0] ROM_ADDR;
    logic            ROM_RD;
    logic [15:0]     ROM_DATA;
    logic            ROM_VALID;
    logic [4:0]      OP;
    logic [2:0]      LR;
    logic [2:0]      SR;
    logic [4:0]      IMM;
    logic            INSTR_VALID;
    logic            nPC_LD;
    logic [PC_W-1:0] JMP_ADDR;
    logic            SKIP;
    logic            SPC;
    logic            SP_D_nU;
    logic [PC_W-1:0] PC;
    logic [SP_W-1:0] SP;
    logic            STK_ERR;

    modport master (
        input  RUN, ROM_DATA, ROM_VALID, nPC_LD, JMP_ADDR, SKIP, SPC, SP_D_nU,
        output ROM_ADDR, ROM_RD, OP, LR, SR, IMM, INSTR_VALID, PC, SP, STK_ERR
    );

    modport slave (
        output RUN, ROM_DATA, ROM_VALID, nPC_LD, JMP_ADDR, SKIP, SPC, SP_D_nU,
        input  ROM_ADDR, ROM_RD, OP, LR, SR, IMM, INSTR_VALID, PC, SP, STK_ERR
    );
endinterface

// File: rtl/ttm4_fetch_unit.sv
// TTM4 instruction fetch / program sequencer: PC, return-address stack, IR,
// and the IDLE/FETCH/EXEC control loop feeding the decoder.
module ttm4_fetch_unit #(
    parameter int unsigned PC_W      = 8,
    parameter int unsigned STK_DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 nRST,
    ttm4_fetch_unit_if.master    bus
);
    localparam int unsigned SP_W  = $clog2(STK_DEPTH) + 1;
    localparam int unsigned IDX_W = $clog2(STK_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic [15:0]     ir_q, ir_d;
    logic            err_q, err_d;
    logic            rom_rd_q, rom_rd_d;
    logic            instr_valid_q, instr_valid_d;

    logic [PC_W-1:0] stack_q [STK_DEPTH];
    logic            push_c;
    logic [PC_W-1:0] pc_inc1_c, pc_inc2_c;
    logic [IDX_W-1:0] push_idx_c, pop_idx_c;
    logic            sp_full_c;

    assign pc_inc1_c  = pc_q + PC_W'(1);
    assign pc_inc2_c  = pc_q + PC_W'(2);
    assign push_idx_c = IDX_W'(sp_q);
    assign pop_idx_c  = IDX_W'(sp_q - SP_W'(1));
    assign sp_full_c  = (sp_q == SP_W'(STK_DEPTH));

    // State and architectural registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            sp_q          <= '0;
            ir_q          <= '0;
            err_q         <= 1'b0;
            rom_rd_q      <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            sp_q          <= sp_d;
            ir_q          <= ir_d;
            err_q         <= err_d;
            rom_rd_q      <= rom_rd_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // Return stack storage; contents are don't-care after reset
    always_ff @(posedge CLK) begin
        if (push_c) begin
            stack_q[push_idx_c] <= pc_inc1_c;
        end
    end

    // Next-state, IR capture and next-PC selection
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        ir_d    = ir_q;
        err_d   = err_q;
        push_c  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.RUN) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.ROM_VALID) begin
                    ir_d    = bus.ROM_DATA;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = bus.RUN ? S_FETCH : S_IDLE;
                // Pop outranks jump; a push only rides along with a taken jump
                if (bus.SPC && bus.SP_D_nU) begin
                    if (sp_q != '0) begin
                        pc_d = stack_q[pop_idx_c];
                        sp_d = sp_q - SP_W'(1);
                    end else begin
                        err_d = 1'b1;
                        pc_d  = pc_inc1_c;
                    end
                end else if (!bus.nPC_LD) begin
                    pc_d = bus.JMP_ADDR;
                    if (bus.SPC) begin
                        if (sp_full_c) begin
                            err_d = 1'b1;
                        end else begin
                            push_c = 1'b1;
                            sp_d   = sp_q + SP_W'(1);
                        end
                    end
                end else if (bus.SKIP) begin
                    pc_d = pc_inc2_c;
                end else begin
                    pc_d = pc_inc1_c;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rom_rd_d      = (state_d == S_FETCH);
        instr_valid_d = (state_d == S_EXEC);
    end

    assign bus.ROM_ADDR    = pc_q;
    assign bus.PC          = pc_q;
    assign bus.ROM_RD      = rom_rd_q;
    assign bus.INSTR_VALID = instr_valid_q;
    assign bus.OP          = ir_q[15:11];
    assign bus.LR          = ir_q[10:8];
    assign bus.SR          = ir_q[7:5];
    assign bus.IMM         = ir_q[4:0];
    assign bus.SP          = sp_q;
    assign bus.STK_ERR     = err_q;
endmodule

// File: tb/tb_ttm4_fetch_unit.sv
// Self-checking bench for ttm4_fetch_unit: directed program-flow scenarios plus
// randomized instruction streams against a queue-based sequencing model.
module tb_ttm4_fetch_unit;
    localparam int unsigned PC_W      = 8;
    localparam int unsigned STK_DEPTH = 4;
    localparam int          PC_MOD    = 1 << PC_W;

    logic CLK;
    logic nRST;

    ttm4_fetch_unit_if #(.PC_W(PC_W), .STK_DEPTH(STK_DEPTH)) bus ();

    ttm4_fetch_unit #(.PC_W(PC_W), .STK_DEPTH(STK_DEPTH)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    int          n_assert;
    int          n_fail;
    int          m_pc;
    int          m_stk[$];
    logic        m_err;
    logic [15:0] m_ir;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_dec_random();
        bus.nPC_LD   = 1'($urandom);
        bus.JMP_ADDR = PC_W'($urandom);
        bus.SKIP     = 1'($urandom);
        bus.SPC      = 1'($urandom);
        bus.SP_D_nU  = 1'($urandom);
    endtask

    // Sequencing model: stack as a queue, PC as an integer modulo 2^PC_W
    task automatic model_exec(input logic npc, input int jmp, input logic skip,
                              input logic spc, input logic dnu);
        if (spc && dnu) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin
                m_err = 1'b1;
                m_pc  = (m_pc + 1) % PC_MOD;
            end
        end else if (!npc) begin
            if (spc) begin
                if (m_stk.size() < int'(STK_DEPTH)) m_stk.push_back((m_pc + 1) % PC_MOD);
                else m_err = 1'b1;
            end
            m_pc = jmp;
        end else begin
            m_pc = (m_pc + (skip ? 2 : 1)) % PC_MOD;
        end
    endtask

    // Entered at a falling edge with the DUT in FETCH; returns at the falling
    // edge one cycle after EXEC ends.
    task automatic instr(input int waits, input logic [15:0] word, input logic npc,
                         input logic [7:0] jmp, input logic skip, input logic spc,
                         input logic dnu, input logic run_after);
        for (int w = 0; w <= waits; w++) begin
            chk("fetch_rd", 32'(bus.ROM_RD), 32'd1);
            chk("fetch_addr", 32'(bus.ROM_ADDR), m_pc);
            chk("fetch_iv", 32'(bus.INSTR_VALID), 32'd0);
            chk("ir_hold", {bus.OP, bus.LR, bus.SR, bus.IMM}, 32'(m_ir));
            bus.ROM_VALID = (w == waits);
            bus.ROM_DATA  = (w == waits) ? word : 16'($urandom);
            bus.RUN       = 1'($urandom);
            drive_dec_random();
            @(negedge CLK);
        end
        m_ir = word;
        chk("exec_iv", 32'(bus.INSTR_VALID), 32'd1);
        chk("exec_op", 32'(bus.OP), 32'(word[15:11]));
        chk("exec_lr", 32'(bus.LR), 32'(word[10:8]));
        chk("exec_sr", 32'(bus.SR), 32'(word[7:5]));
        chk("exec_imm", 32'(bus.IMM), 32'(word[4:0]));
        chk("exec_rd", 32'(bus.ROM_RD), 32'd0);
        chk("exec_pc", 32'(bus.PC), m_pc);
        chk("exec_sp", 32'(bus.SP), m_stk.size());
        bus.ROM_VALID = 1'b0;
        bus.ROM_DATA  = 16'($urandom);
        bus.nPC_LD    = npc;
        bus.JMP_ADDR  = jmp;
        bus.SKIP      = skip;
        bus.SPC       = spc;
        bus.SP_D_nU   = dnu;
        bus.RUN       = run_after;
        model_exec(npc, int'(jmp), skip, spc, dnu);
        @(negedge CLK);
        chk("next_pc", 32'(bus.PC), m_pc);
        chk("next_sp", 32'(bus.SP), m_stk.size());
        chk("next_err", 32'(bus.STK_ERR), 32'(m_err));
        chk("next_rd", 32'(bus.ROM_RD), 32'(run_after));
        chk("next_iv", 32'(bus.INSTR_VALID), 32'd0);
        drive_dec_random();
    endtask

    task automatic nop(input int waits, input logic run_after);
        instr(waits, 16'($urandom), 1'b1, PC_W'($urandom), 1'b0, 1'b0, 1'($urandom), run_after);
    endtask

    task automatic jmp_to(input logic [7:0] target);
        instr(0, 16'($urandom), 1'b0, target, 1'($urandom), 1'b0, 1'($urandom), 1'b1);
    endtask

    task automatic call_to(input logic [7:0] target);
        instr(0, 16'($urandom), 1'b0, target, 1'($urandom), 1'b1, 1'b0, 1'b1);
    endtask

    task automatic ret();
        instr(0, 16'($urandom), 1'($urandom), PC_W'($urandom), 1'($urandom), 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        logic run_r;
        n_assert = 0;
        n_fail   = 0;
        m_pc     = 0;
        m_err    = 1'b0;
        m_ir     = '0;
        nRST          = 1'b0;
        bus.RUN       = 1'b0;
        bus.ROM_VALID = 1'b0;
        bus.ROM_DATA  = '0;
        drive_dec_random();
        repeat (2) @(negedge CLK);

        chk("rst_rd", 32'(bus.ROM_RD), 32'd0);
        chk("rst_pc", 32'(bus.PC), 32'd0);
        chk("rst_addr", 32'(bus.ROM_ADDR), 32'd0);
        chk("rst_sp", 32'(bus.SP), 32'd0);
        chk("rst_iv", 32'(bus.INSTR_VALID), 32'd0);
        chk("rst_err", 32'(bus.STK_ERR), 32'd0);
        chk("rst_ir", {bus.OP, bus.LR, bus.SR, bus.IMM}, 32'd0);

        nRST = 1'b1;
        @(negedge CLK);
        chk("idle_rd", 32'(bus.ROM_RD), 32'd0);
        bus.RUN = 1'b1;
        @(negedge CLK);

        // Straight-line fetch 0..4, then a 3-cycle ROM wait at 0x05
        for (int i = 0; i < 5; i++) nop(0, 1'b1);
        chk("at_05", 32'(bus.ROM_ADDR), 32'h05);
        nop(3, 1'b1);

        jmp_to(8'h10);
        jmp_to(8'h40);
        chk("jmp_40", 32'(bus.ROM_ADDR), 32'h40);

        jmp_to(8'hFE);
        instr(0, 16'($urandom), 1'b1, PC_W'($urandom), 1'b1, 1'b0, 1'($urandom), 1'b1);
        chk("skip_wrap", 32'(bus.PC), 32'h00);

        jmp_to(8'hFF);
        nop(0, 1'b1);
        chk("inc_wrap", 32'(bus.PC), 32'h00);

        jmp_to(8'h20);
        call_to(8'h80);
        chk("call_pc", 32'(bus.PC), 32'h80);
        chk("call_sp", 32'(bus.SP), 32'd1);
        ret();
        chk("ret_pc", 32'(bus.PC), 32'h21);
        chk("ret_sp", 32'(bus.SP), 32'd0);

        // Push strobe without a jump leaves the stack alone
        instr(0, 16'($urandom), 1'b1, PC_W'($urandom), 1'b1, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 5; i++) call_to(PC_W'($urandom));
        chk("ovf_sp", 32'(bus.SP), 32'd4);
        chk("ovf_err", 32'(bus.STK_ERR), 32'd1);
        for (int i = 0; i < 4; i++) ret();

        // Halt, stay idle, then resume
        nop(0, 1'b0);
        repeat (2) begin
            drive_dec_random();
            @(negedge CLK);
            chk("halt_rd", 32'(bus.ROM_RD), 32'd0);
        end
        bus.RUN = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 40; i++) begin
            run_r = ($urandom_range(0, 5) != 0);
            instr($urandom_range(0, 2), 16'($urandom),
                  ($urandom_range(0, 2) != 0), PC_W'($urandom), 1'($urandom),
                  ($urandom_range(0, 2) == 0), 1'($urandom), run_r);
            if (!run_r) begin
                bus.RUN = 1'b1;
                @(negedge CLK);
            end
        end

        // Asynchronous reset in the middle of a fetch
        chk("pre_rst_rd", 32'(bus.ROM_RD), 32'd1);
        bus.ROM_VALID = 1'b0;
        #2 nRST = 1'b0;
        #1;
        chk("arst_rd", 32'(bus.ROM_RD), 32'd0);
        chk("arst_pc", 32'(bus.PC), 32'd0);
        chk("arst_sp", 32'(bus.SP), 32'd0);
        chk("arst_iv", 32'(bus.INSTR_VALID), 32'd0);
        chk("arst_err", 32'(bus.STK_ERR), 32'd0);
        chk("arst_ir", {bus.OP, bus.LR, bus.SR, bus.IMM}, 32'd0);
        @(negedge CLK);
        nRST    = 1'b1;
        bus.RUN = 1'b1;
        m_pc    = 0;
        m_err   = 1'b0;
        m_ir    = '0;
        m_stk.delete();
        @(negedge CLK);

        // Pop on an empty stack
        instr(0, 16'($urandom), 1'b1, PC_W'($urandom), 1'b0, 1'b1, 1'b1, 1'b1);
        chk("uf_err", 32'(bus.STK_ERR), 32'd1);
        chk("uf_pc", 32'(bus.PC), 32'h01);
        nop(1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ttm4_fetch_unit.md
# ttm4_fetch_unit

Instruction fetch and program-sequencing stage of the TTM4 emulator; sits directly upstream of the instruction decoder. It holds the program counter and a small return-address stack, reads 16-bit instruction words from program ROM and presents registered OP/LR/SR fields to the decoder. It then consumes the decoder's PC-load, skip and stack-control outputs to compute the next PC.

## Interface
- PC_W, 8: program counter / ROM address width.
- STK_DEPTH, 4: return-stack entries; a power of 2, ≥2.

- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- RUN  in  1  1 = keep fetching; 0 = halt after the current instruction.
- ROM_ADDR  out  PC_W  fetch address (equals PC).
- ROM_RD  out  1  fetch request.
- ROM_DATA  in  16  instruction word: [15:11] OP, [10:8] LR, [7:5] SR, [4:0] IMM.
- ROM_VALID  in  1  ROM_DATA valid for the current request.
- OP  out  5  registered opcode field to the decoder.
- LR  out  3  registered load-select field.
- SR  out  3  registered store-select field.
- IMM  out  5  registered immediate field.
- INSTR_VALID  out  1  high for exactly the EXEC cycle.
- nPC_LD  in  1  decoder: 0 = load JMP_ADDR.
- JMP_ADDR  in  PC_W  jump target (JRU/JRD concatenation).
- SKIP  in  1  decoder skip-taken: next PC = PC+2.
- SPC  in  1  stack strobe, sampled in EXEC only.
- SP_D_nU  in  1  stack direction: 1 = pop (return), 0 = push (call).
- PC  out  PC_W  current program counter.
- SP  out  clog2(STK_DEPTH)+1  stack occupancy, 0..STK_DEPTH.
- STK_ERR  out  1  sticky overflow/underflow flag.

## Operation
- FSM states: IDLE, FETCH, EXEC.
- IDLE: ROM_RD=0. Goes to FETCH when RUN=1.
- FETCH: ROM_RD=1, ROM_ADDR=PC. When ROM_VALID=1, ROM_DATA loads into IR at that edge and the state goes to EXEC. Otherwise it stays in FETCH; there is no timeout.
- EXEC: INSTR_VALID=1; OP/LR/SR/IMM stable. At the closing edge the next PC is chosen by priority:
  1. SPC=1, SP_D_nU=1, SP>0: PC ← stack[SP-1], SP ← SP-1.
  2. SPC=1, SP_D_nU=1, SP=0: underflow. STK_ERR ← 1, PC ← PC+1.
  3. nPC_LD=0, SPC=1, SP_D_nU=0, SP<STK_DEPTH: stack[SP] ← PC+1, SP ← SP+1, PC ← JMP_ADDR.
  4. nPC_LD=0, SPC=1, SP_D_nU=0, SP=STK_DEPTH: overflow. STK_ERR ← 1; jump still taken; no push.
  5. nPC_LD=0: PC ← JMP_ADDR.
  6. SKIP=1: PC ← PC+2.
  7. Otherwise: PC ← PC+1.
- SPC=1 with SP_D_nU=0 and nPC_LD=1 is a no-op on the stack; the PC rule follows from rule 6/7.
- All PC arithmetic is modulo 2^PC_W; 0xFF+1 = 0x00 and 0xFF+2 = 0x01 (PC_W=8). The pushed value PC+1 wraps the same way.
- After EXEC: FETCH if RUN=1, else IDLE.
- RUN is sampled only in IDLE and at the end of EXEC. Deasserting RUN mid-FETCH does not abort the fetch.
- STK_ERR is cleared only by reset.

## Timing
- Reset values: state IDLE, PC=0, SP=0, OP/LR/SR/IMM=0, INSTR_VALID=0, ROM_RD=0, STK_ERR=0. Stack contents are don't-care.
- Reset asserted mid-FETCH or mid-EXEC: all outputs go to reset values immediately (asynchronously), and the pending update is discarded.
- Minimum 2 cycles per instruction (FETCH with ROM_VALID=1 same cycle, then EXEC); each ROM wait cycle adds 1.
- ROM_ADDR is registered and stable for the whole of FETCH. IR fields change only on the FETCH→EXEC edge and hold through the next FETCH.
- Decoder inputs (nPC_LD, JMP_ADDR, SKIP, SPC, SP_D_nU) are ignored outside EXEC.
- PC and SP update at the same edge that ends EXEC. A stack push and pop never occur together.

## Test plan
- Reset then RUN=1, ROM_VALID tied 1, program of NOPs → ROM_ADDR 0,1,2…; INSTR_VALID high every 2nd cycle; PC wraps 0xFF→0x00.
- ROM_VALID delayed 3 cycles at address 0x05 → ROM_RD held 4 cycles with ROM_ADDR=0x05; IR loads only on the valid cycle.
- At PC=0x10: nPC_LD=0, JMP_ADDR=0x40 → next ROM_ADDR=0x40. Separately, SKIP=1 at PC=0xFE → next PC=0x00.
- Call at PC=0x20 to 0x80 (nPC_LD=0, SPC=1, SP_D_nU=0), then return (SPC=1, SP_D_nU=1) → SP 0→1→0; PC 0x80 then 0x21.
- Five nested calls with STK_DEPTH=4 → 5th call jumps, SP stays 4, STK_ERR=1. Pop with SP=0 after reset → STK_ERR=1, PC+1.
- nRST pulsed low mid-FETCH with ROM_RD=1 → ROM_RD, PC, SP and INSTR_VALID are 0 before the next CLK edge; restart from 0x00.
